// File: rtl/axis_pkt_fifo.sv
// AXI-Stream FIFO with cut-through or store-and-forward draining, length-based re-framing
// of the input stream into tlast-tagged packets, and occupancy/packet-count status.
module axis_pkt_fifo #(
    parameter int unsigned DW        = 8,
    parameter int unsigned AW        = 9,
    parameter int unsigned LW        = 8,
    parameter bit          STORE_FWD = 1'b1
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [DW-1:0] s_tdata,
    input  logic          s_tvalid,
    input  logic          s_tlast,
    output logic          s_tready,
    input  logic [LW-1:0] cfg_len,
    output logic [DW-1:0] m_tdata,
    output logic          m_tvalid,
    output logic          m_tlast,
    input  logic          m_tready,
    output logic [AW:0]   occupancy,
    output logic [AW:0]   pkt_count,
    output logic          frame_err
);

    localparam int unsigned DEPTH = 32'd1 << AW;
    localparam int unsigned EW    = DW + 1;

    logic [EW-1:0] mem [DEPTH];
    logic [AW:0]   wptr, rptr;
    logic [LW-1:0] bcnt, len_q;
    logic          mid_pkt;

    logic          wr, rd, ld, mem_empty;
    logic          len_hit, forced, tag, allow;
    logic [LW-1:0] len_eff;
    logic [AW:0]   pkt_in_mem;
    logic [EW-1:0] rd_word;

    assign s_tready = rst & (occupancy != (AW+1)'(DEPTH));

    // Handshakes, write-side framing and output-stage load decision
    always_comb begin
        wr         = s_tvalid & s_tready;
        rd         = m_tvalid & m_tready;
        mem_empty  = (wptr == rptr);
        len_eff    = (bcnt == '0) ? cfg_len : len_q;
        len_hit    = (len_eff != '0) && (bcnt == len_eff - LW'(1));
        // An untagged beat that would fill the FIFO with no complete packet inside
        // would deadlock store-and-forward, so it closes the packet itself.
        forced     = STORE_FWD && wr && !s_tlast && !len_hit && (pkt_count == '0) &&
                     (occupancy == (AW+1)'(DEPTH - 1)) && !rd;
        tag        = s_tlast | len_hit | forced;
        // Complete packets still in memory, excluding a tagged beat already in the output stage
        pkt_in_mem = pkt_count - (AW+1)'(m_tvalid & m_tlast);
        allow      = !STORE_FWD || (pkt_in_mem != '0) || mid_pkt;
        ld         = !mem_empty && allow && (!m_tvalid || m_tready);
        rd_word    = mem[rptr[AW-1:0]];
    end

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wptr[AW-1:0]] <= {tag, s_tdata};
        end
    end

    always_ff @(posedge clk or negedge rst) begin
        if (!rst) begin
            wptr      <= '0;
            rptr      <= '0;
            bcnt      <= '0;
            len_q     <= '0;
            mid_pkt   <= 1'b0;
            m_tdata   <= '0;
            m_tvalid  <= 1'b0;
            m_tlast   <= 1'b0;
            occupancy <= '0;
            pkt_count <= '0;
            frame_err <= 1'b0;
        end else begin
            frame_err <= forced;
            if (wr) begin
                wptr <= wptr + (AW+1)'(1);
                bcnt <= tag ? '0 : bcnt + LW'(1);
                if (bcnt == '0) begin
                    len_q <= cfg_len;
                end
            end
            if (ld) begin
                rptr     <= rptr + (AW+1)'(1);
                m_tdata  <= rd_word[DW-1:0];
                m_tlast  <= rd_word[DW];
                mid_pkt  <= !rd_word[DW];
                m_tvalid <= 1'b1;
            end else if (rd) begin
                m_tvalid <= 1'b0;
            end
            if (wr && !rd) begin
                occupancy <= occupancy + (AW+1)'(1);
            end else if (!wr && rd) begin
                occupancy <= occupancy - (AW+1)'(1);
            end
            if ((wr && tag) && !(rd && m_tlast)) begin
                pkt_count <= pkt_count + (AW+1)'(1);
            end else if (!(wr && tag) && (rd && m_tlast)) begin
                pkt_count <= pkt_count - (AW+1)'(1);
            end
        end
    end

endmodule

// File: tb/tb_axis_pkt_fifo.sv
// Scoreboard bench for axis_pkt_fifo: a cut-through (index 0) and a store-and-forward
// (index 1) instance, each with a queue-based reference model checked at every negedge.
module tb_axis_pkt_fifo;

    localparam int unsigned DW    = 8;
    localparam int unsigned AW    = 4;
    localparam int unsigned LW    = 8;
    localparam int          DEPTH = 16;

    logic clk = 1'b0;
    logic rst = 1'b0;

    logic [DW-1:0] s_tdata   [2];
    logic          s_tvalid  [2];
    logic          s_tlast   [2];
    logic          s_tready  [2];
    logic [LW-1:0] cfg_len   [2];
    logic [DW-1:0] m_tdata   [2];
    logic          m_tvalid  [2];
    logic          m_tlast   [2];
    logic          m_tready  [2];
    logic [AW:0]   occupancy [2];
    logic [AW:0]   pkt_count [2];
    logic          frame_err [2];

    int checks   = 0;
    int failures = 0;
    bit done0    = 1'b0;
    bit done1    = 1'b0;

    always #5 clk = ~clk;

    function automatic void chk(input int inst, input string name,
                                input logic [63:0] act, input logic [63:0] exp);
        checks++;
        if (act !== exp) begin
            failures++;
            $display("FAIL %s[%0d] at %0t: got 0x%0h expected 0x%0h", name, inst, $time, act, exp);
        end
    endfunction

    for (genvar g = 0; g < 2; g++) begin : g_dut
        localparam bit SF = (g == 1);

        axis_pkt_fifo #(.DW(DW), .AW(AW), .LW(LW), .STORE_FWD(SF)) dut (
            .clk      (clk),
            .rst      (rst),
            .s_tdata  (s_tdata[g]),
            .s_tvalid (s_tvalid[g]),
            .s_tlast  (s_tlast[g]),
            .s_tready (s_tready[g]),
            .cfg_len  (cfg_len[g]),
            .m_tdata  (m_tdata[g]),
            .m_tvalid (m_tvalid[g]),
            .m_tlast  (m_tlast[g]),
            .m_tready (m_tready[g]),
            .occupancy(occupancy[g]),
            .pkt_count(pkt_count[g]),
            .frame_err(frame_err[g])
        );

        // Reference: queue of {tag, data} beats written but not yet read
        logic [DW:0] q[$];
        int mpos    = 0;
        int mlen    = 0;
        bit fe_pend = 1'b0;

        always @(negedge clk) begin : mon
            int ntag;
            int sz;
            bit rd, wr, tag, forced;
            logic [DW:0] e;
            if (!rst) begin
                q.delete();
                mpos    = 0;
                mlen    = 0;
                fe_pend = 1'b0;
            end else begin
                ntag = 0;
                sz   = q.size();
                foreach (q[k]) if (q[k][DW]) ntag++;
                chk(g, "occupancy", 64'(occupancy[g]), 64'(sz));
                chk(g, "pkt_count", 64'(pkt_count[g]), 64'(ntag));
                chk(g, "frame_err", 64'(frame_err[g]), 64'(fe_pend));
                if (SF && m_tvalid[g]) chk(g, "sf_gate_complete_pkt", 64'(ntag != 0), 64'(1));
                rd     = m_tvalid[g] && m_tready[g];
                wr     = s_tvalid[g] && s_tready[g];
                forced = 1'b0;
                if (rd) begin
                    if (sz == 0) begin
                        chk(g, "read_unexpected", 64'(1), 64'(0));
                    end else begin
                        e = q.pop_front();
                        chk(g, "m_tdata", 64'(m_tdata[g]), 64'(e[DW-1:0]));
                        chk(g, "m_tlast", 64'(m_tlast[g]), 64'(e[DW]));
                    end
                end
                if (wr) begin
                    if (mpos == 0) mlen = int'(cfg_len[g]);
                    tag = s_tlast[g] || (mlen != 0 && mpos + 1 == mlen);
                    if (SF && !tag && sz == DEPTH - 1 && !rd && ntag == 0) begin
                        tag    = 1'b1;
                        forced = 1'b1;
                    end
                    q.push_back({tag, s_tdata[g]});
                    mpos = tag ? 0 : mpos + 1;
                end
                fe_pend = forced;
            end
        end
    end

    task automatic send(input int i, input logic [DW-1:0] d, input logic last,
                        input logic [LW-1:0] len);
        bit acc = 1'b0;
        s_tdata[i]  = d;
        s_tlast[i]  = last;
        cfg_len[i]  = len;
        s_tvalid[i] = 1'b1;
        for (int n = 0; n < 300 && !acc; n++) begin
            @(negedge clk);
            acc = s_tready[i];
            @(posedge clk);
            #1;
        end
        s_tvalid[i] = 1'b0;
        chk(i, "send_accepted", 64'(acc), 64'(1));
    endtask

    task automatic drain(input int i);
        m_tready[i] = 1'b1;
        for (int n = 0; n < 200 && occupancy[i] != '0; n++) begin
            @(posedge clk);
            #1;
        end
        chk(i, "drain_empty", 64'(occupancy[i]), 64'(0));
    endtask

    initial begin
        #2000000;
        $display("FAIL watchdog: simulation did not finish");
        $fatal(1, "watchdog");
    end

    initial begin
        for (int i = 0; i < 2; i++) begin
            s_tdata[i]  = '0;
            s_tvalid[i] = 1'b0;
            s_tlast[i]  = 1'b0;
            cfg_len[i]  = '0;
            m_tready[i] = 1'b0;
        end
        repeat (2) @(posedge clk);
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(i, "rst_s_tready", 64'(s_tready[i]), 64'(0));
            chk(i, "rst_m_tvalid", 64'(m_tvalid[i]), 64'(0));
            chk(i, "rst_m_tdata", 64'(m_tdata[i]), 64'(0));
            chk(i, "rst_m_tlast", 64'(m_tlast[i]), 64'(0));
            chk(i, "rst_occupancy", 64'(occupancy[i]), 64'(0));
            chk(i, "rst_pkt_count", 64'(pkt_count[i]), 64'(0));
            chk(i, "rst_frame_err", 64'(frame_err[i]), 64'(0));
        end
        rst = 1'b1;
        #1;
        for (int i = 0; i < 2; i++) chk(i, "post_rst_s_tready", 64'(s_tready[i]), 64'(1));

        // Cut-through: first beat visible one edge after its write
        m_tready[0] = 1'b1;
        send(0, 8'h11, 1'b0, 8'd0);
        chk(0, "ct_not_yet_valid", 64'(m_tvalid[0]), 64'(0));
        @(posedge clk);
        #1;
        chk(0, "ct_first_valid", 64'(m_tvalid[0]), 64'(1));
        chk(0, "ct_first_data", 64'(m_tdata[0]), 64'(8'h11));
        send(0, 8'h12, 1'b0, 8'd0);
        send(0, 8'h13, 1'b0, 8'd0);
        send(0, 8'h14, 1'b1, 8'd0);
        drain(0);

        // Store-and-forward with cfg_len=3: nothing leaves until a packet is complete
        m_tready[1] = 1'b1;
        for (int k = 1; k <= 7; k++) begin
            send(1, DW'(k), 1'b0, 8'd3);
            if (k <= 3) chk(1, "sf_held", 64'(m_tvalid[1]), 64'(0));
            if (k == 4) begin
                chk(1, "sf_release_valid", 64'(m_tvalid[1]), 64'(1));
                chk(1, "sf_release_data", 64'(m_tdata[1]), 64'(1));
            end
        end
        repeat (10) @(posedge clk);
        #1;
        chk(1, "sf_tail_pkt_count", 64'(pkt_count[1]), 64'(0));
        chk(1, "sf_tail_occupancy", 64'(occupancy[1]), 64'(1));
        chk(1, "sf_tail_held", 64'(m_tvalid[1]), 64'(0));
        send(1, 8'h08, 1'b1, 8'd3);
        drain(1);

        // Full under backpressure; a read frees space only for the following cycle
        m_tready[0] = 1'b0;
        for (int k = 0; k < DEPTH; k++) send(0, DW'(8'h40 + k), 1'b0, 8'd0);
        chk(0, "full_s_tready", 64'(s_tready[0]), 64'(0));
        chk(0, "full_occupancy", 64'(occupancy[0]), 64'(DEPTH));
        s_tdata[0]  = 8'h99;
        s_tlast[0]  = 1'b1;
        s_tvalid[0] = 1'b1;
        repeat (3) @(posedge clk);
        #1;
        chk(0, "full_blocks_17th", 64'(occupancy[0]), 64'(DEPTH));
        m_tready[0] = 1'b1;
        @(negedge clk);
        chk(0, "full_ready_not_comb", 64'(s_tready[0]), 64'(0));
        @(posedge clk);
        #1;
        m_tready[0] = 1'b0;
        chk(0, "full_freed_ready", 64'(s_tready[0]), 64'(1));
        @(posedge clk);
        #1;
        s_tvalid[0] = 1'b0;
        chk(0, "full_17th_accepted", 64'(occupancy[0]), 64'(DEPTH));
        drain(0);

        // Forced framing: sixteen untagged beats with no complete packet
        m_tready[1] = 1'b1;
        for (int k = 0; k < DEPTH; k++) send(1, DW'(8'h80 + k), 1'b0, 8'd0);
        chk(1, "forced_frame_err", 64'(frame_err[1]), 64'(1));
        chk(1, "forced_pkt_count", 64'(pkt_count[1]), 64'(1));
        @(posedge clk);
        #1;
        chk(1, "forced_frame_err_pulse", 64'(frame_err[1]), 64'(0));
        drain(1);

        // Early s_tlast ends a packet short; the next packet restarts length counting
        send(1, 8'hC1, 1'b0, 8'd5);
        send(1, 8'hC2, 1'b1, 8'd5);
        for (int k = 0; k < 5; k++) send(1, DW'(8'hD0 + k), 1'b0, 8'd5);
        drain(1);

        // Asynchronous reset between edges with data stored
        m_tready[0] = 1'b0;
        for (int k = 0; k < 6; k++) send(0, DW'(8'h60 + k), 1'b0, 8'd0);
        for (int k = 0; k < 3; k++) send(1, DW'(8'h70 + k), 1'b0, 8'd0);
        chk(0, "pre_rst_occupancy", 64'(occupancy[0]), 64'(6));
        #2;
        rst = 1'b0;
        #1;
        for (int i = 0; i < 2; i++) begin
            chk(i, "async_rst_m_tvalid", 64'(m_tvalid[i]), 64'(0));
            chk(i, "async_rst_occupancy", 64'(occupancy[i]), 64'(0));
            chk(i, "async_rst_pkt_count", 64'(pkt_count[i]), 64'(0));
            chk(i, "async_rst_s_tready", 64'(s_tready[i]), 64'(0));
        end
        @(posedge clk);
        #1;
        rst = 1'b1;
        #1;
        chk(0, "rst_release_s_tready", 64'(s_tready[0]), 64'(1));
        m_tready[0] = 1'b1;
        send(0, 8'hA1, 1'b0, 8'd0);
        send(0, 8'hA2, 1'b1, 8'd0);
        drain(0);
        send(1, 8'hB1, 1'b0, 8'd2);
        send(1, 8'hB2, 1'b0, 8'd2);
        drain(1);

        // Randomized traffic on both instances with random backpressure and cfg_len changes
        fork
            begin
                for (int n = 0; n < 120; n++)
                    send(0, DW'($urandom), ($urandom % 6) == 0, LW'($urandom_range(0, 4)));
                done0 = 1'b1;
            end
            begin
                for (int n = 0; n < 120; n++)
                    send(1, DW'($urandom), ($urandom % 6) == 0, LW'($urandom_range(0, 4)));
                done1 = 1'b1;
            end
            begin
                for (int n = 0; n < 5000 && !(done0 && done1); n++) begin
                    @(posedge clk);
                    #1;
                    m_tready[0] = ($urandom % 4) != 0;
                    m_tready[1] = ($urandom % 3) != 0;
                end
            end
        join
        send(1, 8'hEE, 1'b1, 8'd0);
        drain(0);
        drain(1);
        repeat (2) @(posedge clk);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule

// File: doc/axis_pkt_fifo.md
Name: axis_pkt_fifo

Overview:
- Parametrised AXI-Stream FIFO. Successor to the single-mode byte FIFO.
- Adds selectable cut-through or store-and-forward operation.
- Re-frames the input stream into packets of a programmable beat length, generating m_tlast.
- Exposes occupancy and packet-count status.
- Sits between a stream producer and a packet consumer, for example ahead of a packet-adder/checksum stage.

Parameters:
- DW, 8, tdata width in bits.
- AW, 9, address width; depth = 2**AW entries.
- LW, 8, width of the packet-length config field.
- STORE_FWD, 1, 1 = store-and-forward, 0 = cut-through.

Ports:
- clk  in  1  clock, all logic rising-edge.
- rst  in  1  reset, asynchronous, active-low.
- s_tdata  in  DW  input data.
- s_tvalid  in  1  input beat valid.
- s_tlast  in  1  input end-of-packet.
- s_tready  out  1  FIFO can accept a beat.
- cfg_len  in  LW  beats per output packet; 0 = use s_tlast framing only.
- m_tdata  out  DW  output data.
- m_tvalid  out  1  output beat valid.
- m_tlast  out  1  output end-of-packet.
- m_tready  in  1  downstream accepts.
- occupancy  out  AW+1  entries currently stored, 0..2**AW.
- pkt_count  out  AW+1  complete packets (tlast-tagged beats) stored.
- frame_err  out  1  one-cycle pulse on forced framing.

Behaviour:
- Reset (rst=0, async) values:
  - m_tvalid=0, m_tdata=0, m_tlast=0.
  - occupancy=0, pkt_count=0, frame_err=0.
  - s_tready=0 while rst is low.
  - Pointers, beat counter and latched length are all cleared.
  - Reset mid-packet discards all stored data. The first beat after reset starts a new packet.
- Handshakes:
  - Write = s_tvalid & s_tready.
  - Read = m_tvalid & m_tready.
  - s_tready = rst & (occupancy != 2**AW). It is combinational from registered state.
  - m_tvalid holds until accepted. m_tdata and m_tlast are stable while m_tvalid=1 and m_tready=0.
- Storage:
  - Each entry is DW+1 bits: {tlast_tag, tdata}.
  - Read/write pointers are AW+1 bits; the MSB is the wrap bit.
  - Full when the pointers' low bits are equal and the MSBs differ. Empty when the pointers are equal.
- Framing (write side):
  - Beat counter bcnt, width LW.
  - cfg_len is latched into len_q on the first beat of each packet (bcnt==0). Changes to cfg_len mid-packet take effect at the next packet.
  - tlast_tag = s_tlast | (len_q!=0 & bcnt==len_q-1).
  - bcnt resets to 0 after a tagged beat, otherwise increments.
  - An early s_tlast ends the packet short; no error is raised.
- Forced framing (STORE_FWD=1 only):
  - Trigger: a write would make the FIFO full while pkt_count==0 and the beat is untagged.
  - Action: the beat is tagged tlast, bcnt resets, and frame_err pulses for one cycle. This prevents deadlock.
- Output stage:
  - Single registered output stage fed from memory, first-word fall-through.
  - Cut-through: a beat written at edge N drives m_tvalid=1 from edge N+1 when the FIFO and output stage were empty.
  - Store-forward: the output stage loads only while pkt_count>0, or while the packet currently being drained is unfinished (its tagged beat has not left).
  - Store-forward: m_tvalid rises at edge N+1 after the tagged beat is written at edge N.
- Counters:
  - occupancy counts memory plus output stage.
  - occupancy updates +1 on write, -1 on read, and is unchanged on a simultaneous write and read.
  - pkt_count is +1 on a tagged write and -1 on a tagged read; simultaneous events net to 0.
- Boundaries:
  - At full, s_tready=0. A read in the same cycle frees space for the next cycle only; s_tready is not combinational on m_tready.
  - Empty with m_tready=1 leaves m_tvalid=0 and no pointer moves.
  - Pointer wrap at 2**AW is seamless.
  - cfg_len=1 tags every beat.

Test Plan:
- Cut-through, cfg_len=0: write 4 beats 0x11..0x14 with s_tlast on 0x14, m_tready=1. The first beat appears at the edge after its write; order is preserved; m_tlast only on 0x14; occupancy returns to 0.
- Store-forward, cfg_len=3: stream 7 beats 0x01..0x07 with no s_tlast and m_tready=1.
  - No m_tvalid until 0x03 is written.
  - m_tlast on 0x03 and 0x06.
  - 0x07 is held, pkt_count=0, until cfg_len/s_tlast closes it.
- Backpressure and full, AW=4: write 16 beats with m_tready=0. s_tready drops after the 16th; occupancy=16; a 17th beat is not accepted. Then pulse m_tready for one cycle: s_tready=1 the next cycle and the 17th beat is accepted.
- Forced frame, STORE_FWD=1, AW=4, cfg_len=0, no s_tlast: the 16th beat is tagged, frame_err pulses for exactly one cycle, and 16 beats drain with m_tlast on the last.
- Short packet: cfg_len=5, s_tlast on beat 2, then 5 more beats. m_tlast appears on beat 2 and on beat 7 (the 5th of the new packet).
- Async reset mid-stream: assert rst low between clock edges with occupancy=6. m_tvalid, occupancy and pkt_count are 0 immediately. After release, s_tready=1 and a new 2-beat packet passes intact.
